// File: rtl/alu_op_sequencer.sv
// Issue-side front end for the combinational ALU: decodes R-type requests,
// drives registered ALU inputs, samples the result and returns it with the tag.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [TAGW-1:0]  req_tag,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_illegal,
  output logic [CNTW-1:0]  op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state_r;
  logic [3:0] code_s;
  logic       illegal_s;

  // Returns {illegal, alu_control}; unlisted combinations map to the 1111 code.
  function automatic logic [4:0] decode(input logic [2:0] funct3, input logic funct7b5);
    logic [4:0] res;
    case ({funct3, funct7b5})
      4'b0000: res = 5'b0_0000;
      4'b0001: res = 5'b0_0001;
      4'b1110: res = 5'b0_0010;
      4'b1100: res = 5'b0_0011;
      4'b1000: res = 5'b0_0100;
      4'b0100: res = 5'b0_0101;
      default: res = 5'b1_1111;
    endcase
    return res;
  endfunction

  assign {illegal_s, code_s} = decode(req_funct3, req_funct7b5);

  // Sequencing FSM; every output is a register owned by this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_result   <= {WIDTH{1'b0}};
      rsp_tag      <= {TAGW{1'b0}};
      rsp_illegal  <= 1'b0;
      alu_operand1 <= {WIDTH{1'b0}};
      alu_operand2 <= {WIDTH{1'b0}};
      alu_control  <= 4'b1111;
      op_count     <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            alu_operand1 <= req_rs1;
            alu_operand2 <= req_rs2;
            alu_control  <= code_s;
            rsp_tag      <= req_tag;
            rsp_illegal  <= illegal_s;
            req_ready    <= 1'b0;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          // Illegal requests never expose whatever the ALU makes of code 1111.
          rsp_result <= rsp_illegal ? {WIDTH{1'b0}} : alu_result;
          rsp_valid  <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + {{(CNTW-1){1'b0}}, 1'b1};
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a spec-level model predicts each
// response at accept time and a negedge monitor compares what the DUT returns.
module tb_alu_op_sequencer;
  localparam int WIDTH = 32;
  localparam int TAGW  = 4;
  localparam int CNTW  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid, req_ready, req_funct7b5;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_rs1, req_rs2;
  logic [TAGW-1:0]  req_tag;
  logic [WIDTH-1:0] alu_operand1, alu_operand2, alu_result;
  logic [3:0]       alu_control;
  logic             rsp_valid, rsp_ready, rsp_illegal;
  logic [WIDTH-1:0] rsp_result;
  logic [TAGW-1:0]  rsp_tag;
  logic [CNTW-1:0]  op_count;

  alu_op_sequencer #(.WIDTH(WIDTH), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_control(alu_control), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Environment ALU; an unknown control code yields a loud non-zero pattern.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_operand1 + alu_operand2;
      4'b0001: alu_result = alu_operand1 - alu_operand2;
      4'b0010: alu_result = alu_operand1 & alu_operand2;
      4'b0011: alu_result = alu_operand1 | alu_operand2;
      4'b0100: alu_result = alu_operand1 ^ alu_operand2;
      4'b0101: alu_result = (alu_operand1 < alu_operand2) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  tag;
    logic             illegal;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] got[$];
  int               hs_cyc[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  logic [CNTW-1:0]  exp_count = '0;
  bit               pending_inc = 1'b0;
  bit               rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Reference model written from the operation table, not the control encoding.
  function automatic exp_t model(input logic [2:0] f3, input logic f7,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [TAGW-1:0] tag);
    exp_t e;
    e.tag = tag; e.op1 = a; e.op2 = b; e.illegal = 1'b0;
    if (f3 == 3'd0 && !f7)      begin e.ctrl = 4'd0; e.result = a + b; end
    else if (f3 == 3'd0 && f7)  begin e.ctrl = 4'd1; e.result = a - b; end
    else if (f3 == 3'd7 && !f7) begin e.ctrl = 4'd2; e.result = a & b; end
    else if (f3 == 3'd6 && !f7) begin e.ctrl = 4'd3; e.result = a | b; end
    else if (f3 == 3'd4 && !f7) begin e.ctrl = 4'd4; e.result = a ^ b; end
    else if (f3 == 3'd2 && !f7) begin e.ctrl = 4'd5; e.result = (a < b) ? 32'd1 : 32'd0; end
    else begin e.ctrl = 4'hF; e.result = '0; e.illegal = 1'b1; end
    return e;
  endfunction

  task automatic present(input logic [2:0] f3, input logic f7, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
    req_funct3 = f3; req_funct7b5 = f7; req_rs1 = a; req_rs2 = b; req_tag = tag;
    req_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
    end else begin
      sb.push_back(model(req_funct3, req_funct7b5, req_rs1, req_rs2, req_tag));
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic f7, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
    present(f3, f7, a, b, tag);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0 || rsp_valid) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  // Monitor: checks the EXEC view of the ALU inputs and every response cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pending_inc) exp_count = exp_count + 16'd1;
        pending_inc = 1'b0;
        chk("op_count", op_count, exp_count);
        if (!req_ready && !rsp_valid) begin
          if (sb.size() == 0) fail("exec_without_request");
          else begin
            chk("alu_control", alu_control, sb[0].ctrl);
            chk("alu_operand1", alu_operand1, sb[0].op1);
            chk("alu_operand2", alu_operand2, sb[0].op2);
          end
        end
        if (rsp_valid) begin
          if (sb.size() == 0) fail("spurious_response");
          else begin
            chk("rsp_result", rsp_result, sb[0].result);
            chk("rsp_tag", rsp_tag, sb[0].tag);
            chk("rsp_illegal", rsp_illegal, sb[0].illegal);
            chk("req_ready_in_resp", req_ready, 1'b0);
            if (rsp_ready) begin
              void'(sb.pop_front());
              got.push_back(rsp_result);
              hs_cyc.push_back(cyc);
              pending_inc = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [WIDTH-1:0] held;
    logic [2:0] f3_tab [6];
    f3_tab = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
    req_valid = 1'b0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_tag = '0; rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_control", alu_control, 4'hF);
    chk("rst_op_count", op_count, 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with explicit latency view: EXEC after the accept edge, valid one edge later.
    issue(3'b000, 1'b0, 32'h5, 32'h3, 4'd2);
    chk("lat_exec_no_valid", rsp_valid, 1'b0);
    chk("exec_ctrl_add", alu_control, 4'b0000);
    @(posedge clk); #1;
    chk("lat_valid_after_2_edges", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 32'h8);
    chk("add_tag", rsp_tag, 4'd2);
    @(posedge clk); #1;
    chk("add_count", op_count, 16'd1);

    issue(3'b000, 1'b1, 32'h0, 32'h1, 4'd3);
    chk("exec_ctrl_sub", alu_control, 4'b0001);
    drain();
    chk("sub_result", got[got.size()-1], 32'hFFFF_FFFF);

    // Back-to-back logic ops, rsp_ready held high.
    got.delete(); hs_cyc.delete();
    issue(3'b111, 1'b0, 32'hF0F0_0000, 32'h0FF0_0001, 4'd4);
    issue(3'b110, 1'b0, 32'hF0F0_0000, 32'h0FF0_0001, 4'd5);
    issue(3'b100, 1'b0, 32'hF0F0_0000, 32'h0FF0_0001, 4'd6);
    issue(3'b010, 1'b0, 32'hF0F0_0000, 32'h0FF0_0001, 4'd7);
    drain();
    if (got.size() != 4 || hs_cyc.size() != 4) fail("b2b_count");
    else begin
      chk("and_result", got[0], 32'h00F0_0000);
      chk("or_result",  got[1], 32'hFFF0_0001);
      chk("xor_result", got[2], 32'hFF00_0001);
      chk("slt_result", got[3], 32'h0);
      for (int i = 1; i < 4; i++) chk("b2b_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
    end
    chk("b2b_count_total", op_count, 16'd6);

    issue(3'b001, 1'b0, 32'h7, 32'h7, 4'd8);
    chk("exec_ctrl_illegal", alu_control, 4'hF);
    drain();
    chk("illegal_result", got[got.size()-1], 32'h0);
    chk("illegal_counted", op_count, 16'd7);

    // Backpressure with a competing request held by the producer.
    rsp_ready = 1'b0;
    issue(3'b000, 1'b0, 32'h1234_5678, 32'h1111_1111, 4'd9);
    present(3'b100, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 4'd10);
    @(posedge clk); #1;
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_hold", rsp_result, held);
      @(posedge clk); #1;
    end
    chk("bp_no_accept", alu_operand1, 32'h1234_5678);
    rsp_ready = 1'b1;
    wait_accept();
    chk("bp_pending_op1", alu_operand1, 32'hAAAA_AAAA);
    drain();
    chk("bp_count", op_count, 16'd9);

    // Randomised traffic with random backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic f7;
      int pick = $urandom_range(0, 7);
      if (pick < 6) begin f3 = f3_tab[pick]; f7 = (pick == 1); end
      else begin f3 = 3'($urandom); f7 = 1'($urandom); end
      issue(f3, f7, $urandom, (pick == 5 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom,
            4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_mode = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Asynchronous reset while a request sits in EXEC.
    issue(3'b000, 1'b0, 32'h10, 32'h20, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_result", rsp_result, 32'h0);
    chk("arst_rsp_tag", rsp_tag, 4'd0);
    chk("arst_rsp_illegal", rsp_illegal, 1'b0);
    chk("arst_op1", alu_operand1, 32'h0);
    chk("arst_op2", alu_operand2, 32'h0);
    chk("arst_ctrl", alu_control, 4'hF);
    chk("arst_op_count", op_count, 16'd0);
    sb.delete();
    exp_count = '0;
    pending_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_rsp", rsp_valid, 1'b0);
    chk("post_rst_count", op_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
